// File: rtl/cube_det_pkg.sv
// cube_det_pkg: shared types and default parameters for the cube bounding-box detector.
package cube_det_pkg;
    localparam int PIX_W_D       = 10;
    localparam int COORD_W_D     = 11;
    localparam int DARK_THRESH_D = 0;
    localparam int MIN_RUN_D     = 8;
    localparam int MIN_ROWS_D    = 4;
    typedef logic [COORD_W_D-1:0] coord_t;
    typedef struct packed {
        coord_t x0;
        coord_t y0;
        coord_t x1;
        coord_t y1;
    } bbox_t;
    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} det_state_e;
endpackage

// File: rtl/dark_run_counter.sv
// dark_run_counter: tracks contiguous dark pixels on a line and flags pixels that complete or extend a qualifying run.
module dark_run_counter
    import cube_det_pkg::*;
#(
    parameter int PIX_W       = PIX_W_D,
    parameter int COORD_W     = COORD_W_D,
    parameter int DARK_THRESH = DARK_THRESH_D,
    parameter int MIN_RUN     = MIN_RUN_D
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               clr,
    input  logic               en,
    input  logic               new_line,
    input  logic [COORD_W-1:0] x,
    input  logic [PIX_W-1:0]   pix,
    output logic               qual_pulse,
    output logic [COORD_W-1:0] run_start_x
);
    localparam logic [COORD_W-1:0] RUN_MAX = COORD_W'(MIN_RUN);
    localparam logic [COORD_W:0]   RUN_W   = (COORD_W+1)'(MIN_RUN);
    localparam logic [PIX_W-1:0]   THR     = PIX_W'(DARK_THRESH);
    logic [COORD_W-1:0] run_cnt, prev_x, base, nxt;
    logic [COORD_W:0]   xp1;
    logic               dark, contig;
    always_comb begin
        dark        = pix <= THR;
        base        = (clr || new_line) ? '0 : run_cnt;
        xp1         = {1'b0, x} + (COORD_W+1)'(1);
        contig      = {1'b0, x} == {1'b0, prev_x} + (COORD_W+1)'(1);
        nxt         = !dark ? '0 : !contig ? COORD_W'(1) : base == RUN_MAX ? base : base + COORD_W'(1);
        qual_pulse  = en && nxt == RUN_MAX;
        run_start_x = xp1 < RUN_W ? '0 : COORD_W'(xp1 - RUN_W);
    end
    // a cleared base makes a restarted run count 1 whether or not X looks contiguous
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            run_cnt <= '0;
            prev_x  <= '0;
        end else if (en) begin
            run_cnt <= nxt;
            prev_x  <= x;
        end else if (clr) begin
            run_cnt <= '0;
        end
endmodule

// File: rtl/cube_bbox_detect.sv
// cube_bbox_detect: per-frame bounding box of qualifying dark runs, published one cycle after FrameStart.
module cube_bbox_detect
    import cube_det_pkg::*;
#(
    parameter int PIX_W       = PIX_W_D,
    parameter int COORD_W     = COORD_W_D,
    parameter int DARK_THRESH = DARK_THRESH_D,
    parameter int MIN_RUN     = MIN_RUN_D,
    parameter int MIN_ROWS    = MIN_ROWS_D
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               FrameStart,
    input  logic               ds,
    input  logic [COORD_W-1:0] X_Cont,
    input  logic [COORD_W-1:0] Y_Cont,
    input  logic [PIX_W-1:0]   pixelValue,
    output logic [COORD_W-1:0] CubeX_Start,
    output logic [COORD_W-1:0] CubeY_Start,
    output logic [COORD_W-1:0] CubeX_End,
    output logic [COORD_W-1:0] CubeY_End,
    output logic               CubeDetected,
    output logic               BoxValid
);
    localparam logic [COORD_W-1:0] ROWS_MIN = COORD_W'(MIN_ROWS);
    det_state_e         state;
    logic [COORD_W-1:0] cur_y, qual_rows, min_x, max_x, min_y, max_y;
    logic [COORD_W-1:0] b_cur_y, b_qr, b_min_x, b_max_x, b_min_y, b_max_y;
    logic [COORD_W-1:0] n_qr, n_min_x, n_max_x, n_min_y, n_max_y;
    logic [COORD_W-1:0] p_qr, p_min_y, p_max_y, run_start_x;
    logic               row_qual, b_rq, act, publish, new_line, qual_pulse, p_det, fold;
    dark_run_counter #(
        .PIX_W(PIX_W), .COORD_W(COORD_W), .DARK_THRESH(DARK_THRESH), .MIN_RUN(MIN_RUN)
    ) u_run (
        .Clk(Clk), .Reset(Reset), .clr(FrameStart), .en(act), .new_line(new_line),
        .x(X_Cont), .pix(pixelValue), .qual_pulse(qual_pulse), .run_start_x(run_start_x)
    );
    // b_* are the accumulators as seen by this cycle's pixel: cleared when a new frame starts
    always_comb begin
        publish  = FrameStart && state == SCAN;
        act      = ds && (state == SCAN || FrameStart);
        b_cur_y  = FrameStart ? '0 : cur_y;
        b_rq     = !FrameStart && row_qual;
        b_qr     = FrameStart ? '0 : qual_rows;
        b_min_x  = FrameStart ? '1 : min_x;
        b_max_x  = FrameStart ? '0 : max_x;
        b_min_y  = FrameStart ? '1 : min_y;
        b_max_y  = FrameStart ? '0 : max_y;
        new_line = act && Y_Cont != b_cur_y;
        fold     = new_line && b_rq;
        n_qr     = fold && b_qr != '1 ? b_qr + COORD_W'(1) : b_qr;
        n_min_y  = fold && b_cur_y < b_min_y ? b_cur_y : b_min_y;
        n_max_y  = fold && b_cur_y > b_max_y ? b_cur_y : b_max_y;
        n_min_x  = qual_pulse && run_start_x < b_min_x ? run_start_x : b_min_x;
        n_max_x  = qual_pulse && X_Cont > b_max_x ? X_Cont : b_max_x;
        p_qr     = row_qual && qual_rows != '1 ? qual_rows + COORD_W'(1) : qual_rows;
        p_min_y  = row_qual && cur_y < min_y ? cur_y : min_y;
        p_max_y  = row_qual && cur_y > max_y ? cur_y : max_y;
        p_det    = p_qr >= ROWS_MIN;
    end
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) begin
            state        <= IDLE;
            cur_y        <= '0;
            row_qual     <= 1'b0;
            qual_rows    <= '0;
            min_x        <= '1;
            max_x        <= '0;
            min_y        <= '1;
            max_y        <= '0;
            CubeX_Start  <= '0;
            CubeY_Start  <= '0;
            CubeX_End    <= '0;
            CubeY_End    <= '0;
            CubeDetected <= 1'b0;
            BoxValid     <= 1'b0;
        end else begin
            state     <= FrameStart ? SCAN : state;
            cur_y     <= act ? Y_Cont : b_cur_y;
            row_qual  <= qual_pulse || (b_rq && !new_line);
            qual_rows <= n_qr;
            min_x     <= n_min_x;
            max_x     <= n_max_x;
            min_y     <= n_min_y;
            max_y     <= n_max_y;
            BoxValid  <= publish;
            if (publish) begin
                CubeDetected <= p_det;
                CubeX_Start  <= p_det ? min_x : '0;
                CubeY_Start  <= p_det ? p_min_y : '0;
                CubeX_End    <= p_det ? max_x : '0;
                CubeY_End    <= p_det ? p_max_y : '0;
            end
        end
endmodule
